icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Direct-mapped, read-only instruction cache that answers the fetch stage's instruction-memory requests. It is the responder end of the fetch address/data interface.
- Hits return the 32-bit instruction in the request cycle.
- Misses stall fetch through `imem_resp` while an FSM fills a 256-bit line from physical memory in 4 × 64-bit beats.
- Sits between the fetch stage and the memory arbiter.

Parameters:
- NUM_SETS, 16, number of lines; power of 2, minimum 2.
- BEATS, 4, 64-bit memory beats per line; fixed line size of 32 bytes (8 instruction words).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active low.
- imem_read  input  1  fetch request valid.
- imem_address  input  32  fetch byte address; bits [1:0] ignored.
- imem_rdata  output  32  instruction word; valid only while imem_resp=1.
- imem_resp  output  1  request complete this cycle.
- flush  input  1  invalidate all lines (fence.i / reset of program image).
- pmem_read  output  1  line fill request to memory.
- pmem_address  output  32  line-aligned fill address; bits [4:0] = 0.
- pmem_rdata  input  64  fill beat data.
- pmem_resp  input  1  one beat valid this cycle.

Behaviour:
- Address split:
  - offset = addr[4:2] selects a word in the line.
  - index = addr[5 +: log2(NUM_SETS)].
  - tag = the remaining upper bits.
- Storage: valid, tag and data arrays held in flops. Only the valid bits are reset.
- Reset (rst_n=0, async):
  - all valid bits cleared; state = IDLE; beat counter = 0.
  - imem_resp = 0, pmem_read = 0, pmem_address = 0, imem_rdata = 0.
- Handshake: fetch holds imem_read and imem_address stable until it samples imem_resp=1. A request may drop only after its response.
- IDLE:
  - Hit (valid[index] & tag match & imem_read): imem_resp=1 combinationally in the same cycle, with imem_rdata = line word[offset]. Zero-cycle latency; back-to-back hits give one response per cycle.
  - Miss with imem_read: imem_resp=0; capture the line address; go to FILL next cycle.
  - No request: outputs idle.
- FILL:
  - pmem_read=1 with pmem_address = {tag, index, 5'b0}, held stable for the entire fill.
  - On each pmem_resp, beat[count] = pmem_rdata and count increments; beat 0 carries bytes 0-7 (words 0,1), little-endian.
  - pmem_read stays high until the cycle of the final pmem_resp.
  - On the BEATS-th pmem_resp, go to UPDATE.
- UPDATE (1 cycle):
  - write the assembled line, tag and valid=1 into index; count=0; imem_resp=0.
  - next cycle IDLE, where the held request hits.
  - Miss latency = BEATS memory responses + 2 cycles.
- pmem_resp outside FILL is ignored.
- Flush:
  - Flush in IDLE clears all valid bits at the next edge.
  - Flush coincident with a hit still responds with the current data that cycle.
  - Flush during FILL/UPDATE: the memory burst is completed (never abandoned mid-burst) but the line is written with valid=0, and all other valid bits are cleared. The held request then misses again and refetches.
- Reset mid-fill: state returns to IDLE immediately and pmem_read drops asynchronously. The memory side must tolerate the aborted burst.
- Replacement: a fill overwrites whatever line is at the index (direct-mapped).

Optional Feature:
- Macro: ICACHE_PERF_EN.
- When defined:
  - ports hit_count (32, output) and miss_count (32, output) exist.
  - hit_count increments on every IDLE-state response; miss_count increments on each IDLE→FILL transition.
  - Both counters saturate at 32'hFFFFFFFF, are cleared by rst_n, and are unaffected by flush.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Cold miss, 0x40000000: pmem_read=1 with pmem_address=0x40000000. Return beats 0x00000013_00100093, 0x…, … with 1-cycle gaps → no imem_resp during the fill; imem_resp=1 with imem_rdata=0x00100093 two cycles after the 4th beat.
- Sequential hit, 0x40000004 the next cycle after the fill → imem_resp=1 the same cycle with imem_rdata=0x00000013, and no pmem_read.
- Conflict eviction, NUM_SETS=16: fetch 0x40000200 (same index 0, new tag) → refill from 0x40000200. A subsequent fetch of 0x40000000 misses again and refills from 0x40000000.
- Flush during fill: assert flush at the 2nd beat → the burst completes with all 4 beats consumed; the request misses again and a second fill is issued at the same address; the response arrives after the second fill.
- Async reset mid-fill: drop rst_n between beats → pmem_read=0 immediately; after release, a fetch of the same address misses (valid cleared).
- ICACHE_PERF_EN: run 1 miss followed by 7 hits in the same line → miss_count=1, hit_count=8 (the post-fill response counts as a hit).

Source files
------------

// File: rtl/icache_responder_if.sv
// Fetch-side and memory-side buses of the direct-mapped instruction cache.
// The cache takes the slave modport; the fetch stage and memory model take the master modport.
interface icache_responder_if;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        flush;
  logic        pmem_read;
  logic [31:0] pmem_address;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;

  modport slave (
    input  imem_read, imem_address, flush, pmem_rdata, pmem_resp,
    output imem_rdata, imem_resp, pmem_read, pmem_address
  );

  modport master (
    output imem_read, imem_address, flush, pmem_rdata, pmem_resp,
    input  imem_rdata, imem_resp, pmem_read, pmem_address
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: zero-latency hits, BEATS x 64-bit line fills on a miss.
// Optional hit/miss performance counters are built when ICACHE_PERF_EN is defined.
module icache_responder #(
  parameter int NUM_SETS = 16,
  parameter int BEATS    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  icache_responder_if.slave bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 27 - IDX_W;
  localparam int LINE_W = BEATS * 64;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, FILL, UPDATE} state_t;

  state_t               r_state;
  logic [NUM_SETS-1:0]  r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_SETS];
  logic [LINE_W-1:0]    r_data [NUM_SETS];
  logic [BEATS-1:0][63:0] r_line;
  logic [CNT_W-1:0]     r_count;
  logic [IDX_W-1:0]     r_fill_index;
  logic [TAG_W-1:0]     r_fill_tag;
  logic                 r_flush_pend;
  logic                 r_pmem_read;
  logic [31:0]          r_pmem_address;

  logic [IDX_W-1:0]     w_index;
  logic [TAG_W-1:0]     w_tag;
  logic [2:0]           w_offset;
  logic [LINE_W-1:0]    w_line;
  logic                 w_hit;
  logic                 w_miss;
  logic                 w_beat;

  assign w_index  = bus.imem_address[5 +: IDX_W];
  assign w_tag    = bus.imem_address[31 -: TAG_W];
  assign w_offset = bus.imem_address[4:2];
  assign w_line   = r_data[w_index];

  assign w_hit  = (r_state == IDLE) && bus.imem_read && r_valid[w_index]
                  && (r_tag[w_index] == w_tag);
  assign w_miss = (r_state == IDLE) && bus.imem_read && !w_hit;
  assign w_beat = (r_state == FILL) && bus.pmem_resp;

  // Hits answer combinationally; the word mux forces zero when nothing is being returned.
  assign bus.imem_resp    = w_hit;
  assign bus.imem_rdata   = w_hit ? w_line[{w_offset, 5'b0} +: 32] : 32'h0;
  assign bus.pmem_read    = r_pmem_read;
  assign bus.pmem_address = r_pmem_address;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent races between blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_valid        <= '0;
      r_count        <= '0;
      r_fill_index   <= '0;
      r_fill_tag     <= '0;
      r_flush_pend   <= 1'b0;
      r_pmem_read    <= 1'b0;
      r_pmem_address <= '0;
    end else begin
      if (bus.flush) r_valid <= '0;

      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_state        <= FILL;
            r_fill_index   <= w_index;
            r_fill_tag     <= w_tag;
            r_flush_pend   <= 1'b0;
            r_pmem_read    <= 1'b1;
            r_pmem_address <= {w_tag, w_index, 5'b0};
          end
        end
        FILL: begin
          if (bus.flush) r_flush_pend <= 1'b1;
          if (bus.pmem_resp) begin
            r_count <= r_count + 1'b1;
            if (r_count == LAST_BEAT) begin
              r_pmem_read <= 1'b0;
              r_state     <= UPDATE;
            end
          end
        end
        UPDATE: begin
          // A flush seen at any point of the fill leaves the new line invalid.
          r_valid[r_fill_index] <= !(r_flush_pend || bus.flush);
          r_count               <= '0;
          r_state               <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: tag/data arrays and the beat buffer are deliberately not reset; the valid
  // bits alone decide whether their contents are ever observed.
  always_ff @(posedge clk) begin
    if (w_beat) r_line[r_count] <= bus.pmem_rdata;
    if (r_state == UPDATE) begin
      r_data[r_fill_index] <= r_line;
      r_tag[r_fill_index]  <= r_fill_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit && (r_hit_count != 32'hFFFF_FFFF))   r_hit_count  <= r_hit_count + 32'd1;
      if (w_miss && (r_miss_count != 32'hFFFF_FFFF)) r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Directed, table-driven bench for icache_responder: misses, hits, eviction, flush and reset.
module tb_icache_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_responder_if bus ();

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_responder #(.NUM_SETS(16), .BEATS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  typedef struct {
    string       name;
    logic        rd;
    logic [31:0] addr;
    logic        fl;
    logic        presp;
    logic [63:0] pdata;
    logic        e_resp;
    logic [31:0] e_rdata;
    logic        e_pread;
    logic [31:0] e_paddr;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  logic [63:0] line_a [4] = '{64'h00000013_00100093, 64'h00200113_00300193,
                              64'h00400213_00500293, 64'h00600313_00700393};
  logic [63:0] line_e [4] = '{64'hE1E1E1E1_E0E0E0E0, 64'hE3E3E3E3_E2E2E2E2,
                              64'hE5E5E5E5_E4E4E4E4, 64'hE7E7E7E7_E6E6E6E6};
  logic [63:0] line_f [4] = '{64'hF1F1F1F1_F0F0F0F0, 64'hF3F3F3F3_F2F2F2F2,
                              64'hF5F5F5F5_F4F4F4F4, 64'hF7F7F7F7_F6F6F6F6};

  localparam logic [31:0] ADDR_A = 32'h4000_0000;  // index 0
  localparam logic [31:0] ADDR_E = 32'h4000_0200;  // index 0, different tag
  localparam logic [31:0] ADDR_F = 32'h4000_0040;  // index 2
  localparam logic [31:0] ADDR_G = 32'h4000_0060;  // index 3

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [63:0] b [4], input logic [2:0] w);
    logic [63:0] t;
    t = b[w[2:1]];
    return w[0] ? t[63:32] : t[31:0];
  endfunction

  function automatic void add(input string n, input logic rd, input logic [31:0] a,
                              input logic fl, input logic pr, input logic [63:0] pd,
                              input logic er, input logic [31:0] ed,
                              input logic ep, input logic [31:0] ea);
    vec_t v;
    v.name = n; v.rd = rd; v.addr = a; v.fl = fl; v.presp = pr; v.pdata = pd;
    v.e_resp = er; v.e_rdata = ed; v.e_pread = ep; v.e_paddr = ea;
    vecs.push_back(v);
  endfunction

  // Miss cycle, BEATS beats each preceded by 'gap' idle memory cycles, then the UPDATE cycle.
  function automatic void add_fill(input string n, input logic [31:0] a, input logic [63:0] b [4],
                                   input int gap, input int flush_beat);
    logic [31:0] la;
    la = {a[31:5], 5'b0};
    add({n, "/miss"}, 1'b1, a, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++)
        add($sformatf("%s/gap%0d", n, k), 1'b1, a, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0, 1'b1, la);
      add($sformatf("%s/beat%0d", n, k), 1'b1, a, (k == flush_beat), 1'b1, b[k],
          1'b0, 32'h0, 1'b1, la);
    end
    add({n, "/update"}, 1'b1, a, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endfunction

  function automatic void add_hit(input string n, input logic [31:0] a, input logic [63:0] b [4],
                                  input logic fl, input logic pr);
    add(n, 1'b1, a, fl, pr, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, word_of(b, a[4:2]), 1'b0, 32'h0);
  endfunction

  function automatic void add_idle(input string n);
    add(n, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endfunction

  // Drive on the falling edge, compare 2 ns later, well before the next rising edge.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    bus.imem_read    = v.rd;
    bus.imem_address = v.addr;
    bus.flush        = v.fl;
    bus.pmem_resp    = v.presp;
    bus.pmem_rdata   = v.pdata;
    #2;
    check({v.name, ".resp"}, {63'h0, bus.imem_resp}, {63'h0, v.e_resp});
    if (v.e_resp) check({v.name, ".rdata"}, {32'h0, bus.imem_rdata}, {32'h0, v.e_rdata});
    check({v.name, ".pread"}, {63'h0, bus.pmem_read}, {63'h0, v.e_pread});
    if (v.e_pread) check({v.name, ".paddr"}, {32'h0, bus.pmem_address}, {32'h0, v.e_paddr});
  endtask

  task automatic apply_all();
    foreach (vecs[i]) run_vec(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_read    = 1'b0;
    bus.imem_address = 32'h0;
    bus.flush        = 1'b0;
    bus.pmem_resp    = 1'b0;
    bus.pmem_rdata   = 64'h0;

    repeat (2) @(negedge clk);
    #2;
    check("reset.resp",  {63'h0, bus.imem_resp},    64'h0);
    check("reset.rdata", {32'h0, bus.imem_rdata},   64'h0);
    check("reset.pread", {63'h0, bus.pmem_read},    64'h0);
    check("reset.paddr", {32'h0, bus.pmem_address}, 64'h0);
    rst_n = 1'b1;

    // Cold miss with 1-cycle beat gaps, then the held request and 7 more hits in the line.
    add_fill("cold_a", ADDR_A, line_a, 1, -1);
    for (int w = 0; w < 8; w++)
      add_hit($sformatf("hit_a%0d", w), ADDR_A + 32'(w * 4), line_a, 1'b0, 1'b0);
    add_idle("idle0");
    apply_all();

`ifdef ICACHE_PERF_EN
    check("perf.miss_count", {32'h0, miss_count}, 64'd1);
    check("perf.hit_count",  {32'h0, hit_count},  64'd8);
`endif

    // Stray pmem_resp in IDLE must not disturb the line; then eviction and refill.
    add_hit("stray_resp", ADDR_A + 32'h10, line_a, 1'b0, 1'b1);
    add_hit("after_stray", ADDR_A + 32'h14, line_a, 1'b0, 1'b0);
    add_fill("evict_e", ADDR_E, line_e, 0, -1);
    add_hit("hit_e7", ADDR_E + 32'h1C, line_e, 1'b0, 1'b0);
    add_fill("refill_a", ADDR_A, line_a, 0, -1);
    add_hit("hit_a1_again", ADDR_A + 32'h4, line_a, 1'b0, 1'b0);

    // Flush at the 2nd beat: burst completes, the line stays invalid, and A is cleared too.
    add_fill("flush_f", ADDR_F, line_f, 0, 1);
    add_fill("refetch_f", ADDR_F, line_f, 1, -1);
    add_hit("hit_f0", ADDR_F, line_f, 1'b0, 1'b0);
    add_fill("a_cleared", ADDR_A, line_a, 0, -1);
    add_hit("hit_a0", ADDR_A, line_a, 1'b0, 1'b0);

    // Flush coincident with a hit: data returned that cycle, line gone afterwards.
    add_hit("flush_hit", ADDR_A + 32'h8, line_a, 1'b1, 1'b0);
    add_fill("post_flush_hit", ADDR_A + 32'h8, line_a, 0, -1);
    add_hit("hit_a2", ADDR_A + 32'h8, line_a, 1'b0, 1'b0);

    // Start a fill of G and take one beat before the asynchronous reset.
    add_fill("abort_g", ADDR_G, line_a, 0, -1);
    for (int i = 0; i < 4; i++) void'(vecs.pop_back());
    apply_all();

    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset.pread", {63'h0, bus.pmem_read}, 64'h0);
    bus.imem_read = 1'b0;
    bus.pmem_resp = 1'b0;
    @(negedge clk);
    #2;
    check("in_reset.resp",  {63'h0, bus.imem_resp},    64'h0);
    check("in_reset.paddr", {32'h0, bus.pmem_address}, 64'h0);
    rst_n = 1'b1;

    // A was valid before reset; it must miss now.
    add_fill("after_reset_a", ADDR_A, line_a, 1, -1);
    add_hit("hit_a7", ADDR_A + 32'h1C, line_a, 1'b0, 1'b0);
    add_idle("idle_end");
    apply_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
